// File: rtl/dvp_tx_rgb565.sv
// dvp_tx_rgb565: camera-side DVP transmitter. Turns an RGB565 pixel stream into
// OV2640-style VSYNC/HREF/PIXDATA, two bytes per pixel, with I_clk doubling as PIXCLK.
// Ports: I_clk/I_rst_n clock and async active-low reset; I_en frame enable;
//   I_pix_valid/I_pix_data pixel source, O_pix_ready accept strobe (source cannot stall us);
//   O_vsync/O_href/O_pixdata DVP bus; O_frame_done end-of-frame pulse; O_underrun substituted pixel.
module dvp_tx_rgb565 #(
    parameter int H_ACT   = 800,
    parameter int V_ACT   = 600,
    parameter int H_BLANK = 288,
    parameter int VS_LEN  = 4,
    parameter int V_BP    = 20,
    parameter int V_FP    = 4,
    parameter bit VS_POL  = 1'b1
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_en,
    input  logic        I_pix_valid,
    input  logic [15:0] I_pix_data,
    output logic        O_pix_ready,
    output logic        O_vsync,
    output logic        O_href,
    output logic [9:0]  O_pixdata,
    output logic        O_frame_done,
    output logic        O_underrun
);
    localparam int L      = 2 * H_ACT + H_BLANK;
    localparam int MAX_AB = (VS_LEN > V_BP) ? VS_LEN : V_BP;
    localparam int MAX_CD = (V_ACT > V_FP) ? V_ACT : V_FP;
    localparam int MAX_LN = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int BW     = (L > 1) ? $clog2(L) : 1;
    localparam int LW     = (MAX_LN > 1) ? $clog2(MAX_LN) : 1;

    localparam logic [BW-1:0] BYTE_LAST = BW'(L - 1);
    localparam logic [BW-1:0] HREF_END  = BW'(2 * H_ACT);
    localparam logic [BW-1:0] RDY_END   = BW'(2 * H_ACT - 1);
    localparam logic [LW-1:0] VS_LAST   = LW'(VS_LEN - 1);
    localparam logic [LW-1:0] VBP_LAST  = LW'(V_BP - 1);
    localparam logic [LW-1:0] VACT_LAST = LW'(V_ACT - 1);
    localparam logic [LW-1:0] VFP_LAST  = LW'(V_FP - 1);

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP} state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   byte_q, byte_d;
    logic [LW-1:0]   line_q, line_d;
    logic [LW-1:0]   line_last;

    logic            vsync_q, vsync_d;
    logic            href_q, href_d;
    logic            ready_q, ready_d;
    logic [9:0]      pixdata_q, pixdata_d;
    logic            fdone_q, fdone_d;
    logic            underrun_q, underrun_d;
    logic [7:0]      pix_lo_q, pix_lo_d;

    // State and counters
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= S_IDLE;
            byte_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            line_q  <= line_d;
        end
    end

    // Next state: every non-idle state runs whole lines of L cycles
    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        line_d    = line_q;
        line_last = '0;
        case (state_q)
            S_VSYNC:  line_last = VS_LAST;
            S_VBP:    line_last = VBP_LAST;
            S_ACTIVE: line_last = VACT_LAST;
            S_VFP:    line_last = VFP_LAST;
            default:  line_last = '0;
        endcase
        if (state_q == S_IDLE) begin
            if (I_en) begin
                state_d = S_VSYNC;
                byte_d  = '0;
                line_d  = '0;
            end
        end else if (byte_q == BYTE_LAST) begin
            byte_d = '0;
            if (line_q == line_last) begin
                line_d = '0;
                case (state_q)
                    S_VSYNC:  state_d = S_VBP;
                    S_VBP:    state_d = S_ACTIVE;
                    S_ACTIVE: state_d = S_VFP;
                    default:  state_d = I_en ? S_VSYNC : S_IDLE;
                endcase
            end else begin
                line_d = line_q + LW'(1);
            end
        end else begin
            byte_d = byte_q + BW'(1);
        end
    end

    // Outputs are decoded from the next state so the registered pins line up
    // with the state registers (no extra cycle of lag).
    always_comb begin
        vsync_d = (state_d == S_VSYNC) ? VS_POL : ~VS_POL;
        href_d  = (state_d == S_ACTIVE) && (byte_d < HREF_END);
        // Ready leads each even byte by one cycle: odd slots inside the line,
        // plus the last cycle of the line preceding an active line.
        ready_d = ((state_d == S_ACTIVE) && byte_d[0] && (byte_d < RDY_END)) ||
                  ((byte_d == BYTE_LAST) &&
                   (((state_d == S_VBP) && (line_d == VBP_LAST)) ||
                    ((state_d == S_ACTIVE) && (line_d != VACT_LAST))));
        fdone_d    = (state_d == S_VFP) && (line_d == VFP_LAST) && (byte_d == BYTE_LAST);
        underrun_d = ready_q & ~I_pix_valid;

        pix_lo_d  = pix_lo_q;
        pixdata_d = '0;
        if (ready_q) begin
            // A missing pixel is replaced by black; timing is not disturbed.
            pixdata_d = {(I_pix_valid ? I_pix_data[15:8] : 8'h00), 2'b00};
            pix_lo_d  = I_pix_valid ? I_pix_data[7:0] : 8'h00;
        end else if (href_d && byte_d[0]) begin
            pixdata_d = {pix_lo_q, 2'b00};
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            vsync_q    <= ~VS_POL;
            href_q     <= 1'b0;
            ready_q    <= 1'b0;
            pixdata_q  <= '0;
            fdone_q    <= 1'b0;
            underrun_q <= 1'b0;
            pix_lo_q   <= '0;
        end else begin
            vsync_q    <= vsync_d;
            href_q     <= href_d;
            ready_q    <= ready_d;
            pixdata_q  <= pixdata_d;
            fdone_q    <= fdone_d;
            underrun_q <= underrun_d;
            pix_lo_q   <= pix_lo_d;
        end
    end

    assign O_vsync      = vsync_q;
    assign O_href       = href_q;
    assign O_pix_ready  = ready_q;
    assign O_pixdata    = pixdata_q;
    assign O_frame_done = fdone_q;
    assign O_underrun   = underrun_q;
endmodule

// File: tb/tb_dvp_tx_rgb565.sv
// Testbench for dvp_tx_rgb565 on a small frame (L=14, F=84): per-cycle reference
// model built from line/frame arithmetic, a pixel-format vector table, and hand
// sequences for underrun, enable drop, back-to-back frames and async reset.
module tb_dvp_tx_rgb565;
    localparam int H_ACT   = 4;
    localparam int V_ACT   = 3;
    localparam int H_BLANK = 6;
    localparam int VS_LEN  = 1;
    localparam int V_BP    = 1;
    localparam int V_FP    = 1;
    localparam bit VS_POL  = 1'b1;
    localparam int L       = 2 * H_ACT + H_BLANK;
    localparam int F       = (VS_LEN + V_BP + V_ACT + V_FP) * L;
    localparam int NLOG    = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        pv = 1'b0;
    logic [15:0] pd = 16'h0;
    logic        rdy, vs, hr, fd, ur;
    logic [9:0]  dat;

    dvp_tx_rgb565 #(
        .H_ACT(H_ACT), .V_ACT(V_ACT), .H_BLANK(H_BLANK), .VS_LEN(VS_LEN),
        .V_BP(V_BP), .V_FP(V_FP), .VS_POL(VS_POL)
    ) dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_en(en), .I_pix_valid(pv), .I_pix_data(pd),
        .O_pix_ready(rdy), .O_vsync(vs), .O_href(hr), .O_pixdata(dat),
        .O_frame_done(fd), .O_underrun(ur)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       vsync;
        logic       href;
        logic       ready;
        logic       fdone;
        logic       undr;
        logic [9:0] pd;
    } out_t;

    typedef struct {
        logic [15:0] pix;
        logic [9:0]  even;
        logic [9:0]  odd;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          n_frames = 0;
    bit          use_tbl = 1'b0;
    logic        in_v [NLOG];
    logic [15:0] in_d [NLOG];
    out_t        out_log [NLOG];
    vec_t        tbl [4];

    task automatic chk(input string name, input int cyc, input logic [14:0] got, input logic [14:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    function automatic bit is_href(int t);
        int f, ln, b;
        f  = t % F;
        ln = f / L;
        b  = f % L;
        return (ln >= VS_LEN + V_BP) && (ln < VS_LEN + V_BP + V_ACT) && (b < 2 * H_ACT);
    endfunction

    // Ready is expected exactly one cycle ahead of every even active byte.
    function automatic bit ready_at(int t);
        if (t < 0 || t + 1 >= n_frames * F) return 1'b0;
        return is_href(t + 1) && (((t + 1) % L) % 2 == 0);
    endfunction

    function automatic out_t model(int t);
        out_t o;
        int   b;
        o = '0;
        o.vsync = !VS_POL;
        if (t >= n_frames * F) return o;
        b = t % L;
        o.vsync = ((t % F) < VS_LEN * L) ? VS_POL : !VS_POL;
        o.href  = is_href(t);
        o.ready = ready_at(t);
        o.fdone = ((t % F) == F - 1);
        if (t >= 1 && ready_at(t - 1)) o.undr = !in_v[t - 1];
        if (o.href) begin
            if (b % 2 == 0) o.pd = in_v[t - 1] ? {in_d[t - 1][15:8], 2'b00} : 10'h000;
            else            o.pd = in_v[t - 2] ? {in_d[t - 2][7:0], 2'b00} : 10'h000;
        end
        return o;
    endfunction

    // mode 0: deterministic pixel sequence, valid except at bad_cyc
    // mode 1: random valid/data with enable;  mode 2: random inputs, enable off
    task automatic run(input int ncyc, input int mode, input int drop_at, input int nfr, input int bad_cyc);
        int   k;
        out_t got;
        k = 0;
        n_frames = nfr;
        en = (mode != 2);
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            got = {vs, hr, rdy, fd, ur, dat};
            out_log[t] = got;
            chk("cycle", t, got, model(t));
            if (t == drop_at) en = 1'b0;
            if (mode != 0) begin
                pv = ($urandom_range(3) != 0);
                pd = 16'($urandom);
            end else begin
                pv = (t != bad_cyc);
                if (use_tbl) pd = (k < 4) ? tbl[k].pix : 16'h1000 + 16'(k);
                else         pd = 16'hF800 + 16'(k);
                if (ready_at(t) && pv) k++;
            end
            in_v[t] = pv;
            in_d[t] = pd;
        end
    endtask

    initial begin
        out_t idle;
        tbl[0] = '{16'hF800, 10'h3E0, 10'h000};
        tbl[1] = '{16'h07E0, 10'h01C, 10'h380};
        tbl[2] = '{16'h001F, 10'h000, 10'h07C};
        tbl[3] = '{16'hA5C3, 10'h294, 10'h30C};
        idle = '0;
        idle.vsync = !VS_POL;

        // Reset state, then 200 idle cycles with enable low
        repeat (3) @(negedge clk);
        chk("reset_state", 0, {vs, hr, rdy, fd, ur, dat}, idle);
        rst_n = 1'b1;
        run(200, 2, -1, 0, -1);

        // Frame A: table pixels on line 0, enable dropped at cycle 40
        use_tbl = 1'b1;
        run(160, 0, 40, 1, -1);
        for (int i = 0; i < 4; i++) begin
            chk("tbl_even", 28 + 2 * i, out_log[28 + 2 * i].pd, tbl[i].even);
            chk("tbl_odd",  29 + 2 * i, out_log[29 + 2 * i].pd, tbl[i].odd);
        end
        chk("vs_c0",    0,  out_log[0].vsync,  1'b1);
        chk("vs_c13",   13, out_log[13].vsync, 1'b1);
        chk("vs_c14",   14, out_log[14].vsync, 1'b0);
        chk("rdy_c27",  27, out_log[27].ready, 1'b1);
        chk("href_c27", 27, out_log[27].href,  1'b0);
        chk("href_c28", 28, out_log[28].href,  1'b1);
        chk("href_c35", 35, out_log[35].href,  1'b1);
        chk("href_c36", 36, out_log[36].href,  1'b0);
        chk("href_c42", 42, out_log[42].href,  1'b1);
        chk("href_c63", 63, out_log[63].href,  1'b1);
        chk("href_c64", 64, out_log[64].href,  1'b0);
        chk("fdone_c83", 83, out_log[83].fdone, 1'b1);
        chk("idle_vs_c84", 84, out_log[84].vsync, 1'b0);
        chk("idle_vs_c159", 159, out_log[159].vsync, 1'b0);

        // Frame B: incrementing from F800, underrun at 2nd ready, two frames back-to-back
        use_tbl = 1'b0;
        run(200, 0, 100, 2, 29);
        chk("first_even", 28, out_log[28].pd, 10'h3E0);
        chk("first_odd",  29, out_log[29].pd, 10'h000);
        chk("undr_c30",   30, out_log[30].undr, 1'b1);
        chk("undr_c28",   28, out_log[28].undr, 1'b0);
        chk("udata_c30",  30, out_log[30].pd, 10'h000);
        chk("udata_c31",  31, out_log[31].pd, 10'h000);
        chk("href_c30",   30, out_log[30].href, 1'b1);
        chk("after_undr", 32, out_log[32].pd, {8'hF8, 2'b00});
        chk("fdone_b83",  83, out_log[83].fdone, 1'b1);
        chk("vs_b83",     83, out_log[83].vsync, 1'b0);
        chk("vs_b84",     84, out_log[84].vsync, 1'b1);
        chk("href_b112",  112, out_log[112].href, 1'b1);

        // Random source, two frames
        run(200, 1, 90, 2, -1);

        // Async reset at cycle 45 (mid-HREF), then restart from VSYNC line 0
        run(46, 1, -1, 1, -1);
        rst_n = 1'b0;
        #1;
        chk("rst_href",  45, hr,  1'b0);
        chk("rst_pdata", 45, dat, 10'h000);
        chk("rst_all",   45, {vs, hr, rdy, fd, ur, dat}, idle);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(100, 1, 5, 1, -1);
        chk("restart_vs", 0, out_log[0].vsync, 1'b1);
        chk("restart_href", 28, out_log[28].href, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
